// File: rtl/fpu_pkg.sv
// Shared FP adder constants: per-precision field sizes, normaliser state encoding
// and the all-ones (infinity/NaN) exponent pattern.
package fpu_pkg;

  localparam int HALF_EXP_SIZE    = 5;
  localparam int SINGLE_EXP_SIZE  = 8;
  localparam int DOUBLE_EXP_SIZE  = 11;

  localparam int HALF_MANT_SIZE   = 11;
  localparam int SINGLE_MANT_SIZE = 24;
  localparam int DOUBLE_MANT_SIZE = 53;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Wide enough for double; narrower formats slice the low bits.
  localparam logic [DOUBLE_EXP_SIZE-1:0] EXP_ALL_ONES = '1;

endpackage

// File: rtl/norm_shift_step.sv
// One normalisation step: decides zero/carry/normal/denormal or a single left shift.
// Purely combinational; the caller registers the result each cycle.
module norm_shift_step
  import fpu_pkg::*;
#(
  parameter int ExponentSize = SINGLE_EXP_SIZE,
  parameter int MantissaSize = SINGLE_MANT_SIZE,
  parameter int CountSize    = 6
) (
  input  logic [ExponentSize-1:0] exponent,
  input  logic [MantissaSize:0]   mantissa,
  input  logic [CountSize-1:0]    shift_count,
  output logic [ExponentSize-1:0] next_exponent,
  output logic [MantissaSize:0]   next_mantissa,
  output logic [CountSize-1:0]    next_shift_count,
  output logic                    next_sticky,
  output logic                    next_overflow,
  output logic                    next_underflow,
  output logic                    next_zero,
  output logic                    finished
);

  localparam logic [ExponentSize-1:0] ExpMax = EXP_ALL_ONES[ExponentSize-1:0];
  localparam logic [ExponentSize-1:0] ExpOne = ExponentSize'(1);

  logic [ExponentSize-1:0] exp_inc;
  assign exp_inc = exponent + ExpOne;

  always_comb begin
    next_exponent    = exponent;
    next_mantissa    = mantissa;
    next_shift_count = shift_count;
    next_sticky      = 1'b0;
    next_overflow    = 1'b0;
    next_underflow   = 1'b0;
    next_zero        = 1'b0;
    finished         = 1'b0;

    if (mantissa == '0) begin
      next_exponent = '0;
      next_zero     = 1'b1;
      finished      = 1'b1;
    end else if (mantissa[MantissaSize]) begin
      next_mantissa = {1'b0, mantissa[MantissaSize:1]};
      next_sticky   = mantissa[0];
      next_exponent = exp_inc;
      if (exp_inc == ExpMax) begin
        next_overflow = 1'b1;
        next_mantissa = '0;
      end
      finished = 1'b1;
    end else if (mantissa[MantissaSize-1]) begin
      // Two denormals can sum to a normal; it then needs the minimum normal exponent.
      if (exponent == '0) begin
        next_exponent = ExpOne;
      end
      finished = 1'b1;
    end else if (exponent <= ExpOne) begin
      next_exponent  = '0;
      next_underflow = 1'b1;
      finished       = 1'b1;
    end else begin
      next_mantissa    = {mantissa[MantissaSize-1:0], 1'b0};
      next_exponent    = exponent - ExpOne;
      next_shift_count = shift_count + CountSize'(1);
    end
  end

endmodule

// File: rtl/mantissa_normalizer.sv
// Post-add normaliser: one right shift on carry or one left shift per cycle; OutValid N+1
// edges after accept (N = ShiftCount). Result held until OutReady; InReady only when idle.
module mantissa_normalizer
  import fpu_pkg::*;
#(
  parameter int ExponentSize = SINGLE_EXP_SIZE,
  parameter int MantissaSize = SINGLE_MANT_SIZE,
  parameter int CountSize    = 6
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic                    SignIn,
  input  logic [ExponentSize-1:0] ExponentIn,
  input  logic [MantissaSize:0]   MantissaIn,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic                    SignOut,
  output logic [ExponentSize-1:0] ExponentOut,
  output logic [MantissaSize-1:0] MantissaOut,
  output logic [CountSize-1:0]    ShiftCount,
  output logic                    Sticky,
  output logic                    Overflow,
  output logic                    Underflow,
  output logic                    Zero
);

  logic [1:0]              state;
  logic [ExponentSize-1:0] exponent;
  logic [MantissaSize:0]   mantissa;

  logic [ExponentSize-1:0] step_exponent;
  logic [MantissaSize:0]   step_mantissa;
  logic [CountSize-1:0]    step_shift_count;
  logic                    step_sticky;
  logic                    step_overflow;
  logic                    step_underflow;
  logic                    step_zero;
  logic                    step_finished;

  norm_shift_step #(
    .ExponentSize(ExponentSize),
    .MantissaSize(MantissaSize),
    .CountSize   (CountSize)
  ) u_step (
    .exponent        (exponent),
    .mantissa        (mantissa),
    .shift_count     (ShiftCount),
    .next_exponent   (step_exponent),
    .next_mantissa   (step_mantissa),
    .next_shift_count(step_shift_count),
    .next_sticky     (step_sticky),
    .next_overflow   (step_overflow),
    .next_underflow  (step_underflow),
    .next_zero       (step_zero),
    .finished        (step_finished)
  );

  assign InReady     = (state == ST_IDLE);
  assign ExponentOut = exponent;
  // The carry bit is always clear once normalisation has finished.
  assign MantissaOut = mantissa[MantissaSize-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      OutValid   <= 1'b0;
      SignOut    <= 1'b0;
      exponent   <= '0;
      mantissa   <= '0;
      ShiftCount <= '0;
      Sticky     <= 1'b0;
      Overflow   <= 1'b0;
      Underflow  <= 1'b0;
      Zero       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (InValid) begin
            SignOut    <= SignIn;
            exponent   <= ExponentIn;
            mantissa   <= MantissaIn;
            ShiftCount <= '0;
            Sticky     <= 1'b0;
            Overflow   <= 1'b0;
            Underflow  <= 1'b0;
            Zero       <= 1'b0;
            state      <= ST_NORM;
          end
        end
        ST_NORM: begin
          exponent   <= step_exponent;
          mantissa   <= step_mantissa;
          ShiftCount <= step_shift_count;
          Sticky     <= step_sticky;
          Overflow   <= step_overflow;
          Underflow  <= step_underflow;
          Zero       <= step_zero;
          if (step_finished) begin
            OutValid <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          OutValid <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Scoreboard bench for mantissa_normalizer (single precision): directed vectors,
// expected results queued at issue and checked by an independent output monitor.
module tb_mantissa_normalizer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic        SignIn;
  logic [7:0]  ExponentIn;
  logic [24:0] MantissaIn;
  logic        OutValid;
  logic        OutReady;
  logic        SignOut;
  logic [7:0]  ExponentOut;
  logic [23:0] MantissaOut;
  logic [5:0]  ShiftCount;
  logic        Sticky;
  logic        Overflow;
  logic        Underflow;
  logic        Zero;

  mantissa_normalizer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .SignIn     (SignIn),
    .ExponentIn (ExponentIn),
    .MantissaIn (MantissaIn),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .SignOut    (SignOut),
    .ExponentOut(ExponentOut),
    .MantissaOut(MantissaOut),
    .ShiftCount (ShiftCount),
    .Sticky     (Sticky),
    .Overflow   (Overflow),
    .Underflow  (Underflow),
    .Zero       (Zero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        sign;
    logic [7:0]  e;
    logic [23:0] m;
    logic [5:0]  sc;
    logic        st;
    logic        ov;
    logic        un;
    logic        z;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_sent = 0;
  int   n_done = 0;
  logic prev_vld = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_out(input exp_t e, input string tag);
    chk({tag, "_sign"}, 32'(SignOut), 32'(e.sign));
    chk({tag, "_exponent"}, 32'(ExponentOut), 32'(e.e));
    chk({tag, "_mantissa"}, 32'(MantissaOut), 32'(e.m));
    chk({tag, "_shift_count"}, 32'(ShiftCount), 32'(e.sc));
    chk({tag, "_flags"}, 32'({Sticky, Overflow, Underflow, Zero}),
        32'({e.st, e.ov, e.un, e.z}));
  endtask

  // Monitor: pops on OutValid rise, then checks the result stays frozen while held.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (OutValid && !prev_vld) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(OutValid), 32'd0);
        end else begin
          cur = sb.pop_front();
          check_out(cur, "result");
          chk("latency", 32'(cyc - cur.acc), 32'(cur.sc) + 32'd1);
        end
      end else if (OutValid) begin
        check_out(cur, "held");
      end
      if (OutValid) chk("in_ready_while_done", 32'(InReady), 32'd0);
      if (OutValid && OutReady) n_done++;
    end
    prev_vld = OutValid;
  end

  // Holds InValid until the block is idle, so a request during DONE waits for the handshake.
  task automatic send(input logic s, input logic [7:0] e_in, input logic [24:0] m_in,
                      input logic [7:0] e_out, input logic [23:0] m_out, input logic [5:0] sc,
                      input logic st, input logic ov, input logic un, input logic z);
    exp_t x;
    int guard = 0;
    @(negedge Clk);
    InValid    = 1'b1;
    SignIn     = s;
    ExponentIn = e_in;
    MantissaIn = m_in;
    while (!InReady && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    chk("accept_timeout", 32'(guard < 200), 32'd1);
    x.sign = s; x.e = e_out; x.m = m_out; x.sc = sc;
    x.st = st; x.ov = ov; x.un = un; x.z = z;
    x.acc = cyc + 1;
    sb.push_back(x);
    n_sent++;
    @(negedge Clk);
    InValid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(OutValid), 32'd0);
    chk({tag, "_in_ready"}, 32'(InReady), 32'd1);
    chk({tag, "_data"}, 32'({SignOut, ExponentOut, ShiftCount}), 32'd0);
    chk({tag, "_mantissa"}, 32'(MantissaOut), 32'd0);
    chk({tag, "_flags"}, 32'({Sticky, Overflow, Underflow, Zero}), 32'd0);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((sb.size() != 0 || OutValid) && guard < 300) begin
      @(negedge Clk);
      guard++;
    end
    chk({tag, "_drain_timeout"}, 32'(guard < 300), 32'd1);
  endtask

  initial begin
    int guard;
    Reset = 1'b1; InValid = 1'b0; SignIn = 1'b0; ExponentIn = '0; MantissaIn = '0;
    OutReady = 1'b1;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b0;

    //   sign  E_in   M_in           E_out  M_out      SC  St Ov Un Z
    send(1'b0, 8'h80, 25'h1800001, 8'h81, 24'hC00000, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b1, 8'h10, 25'h0100000, 8'h0D, 24'h800000, 6'd3,  1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h03, 25'h0000100, 8'h00, 24'h000400, 6'd2,  1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b0, 8'hFE, 25'h1000000, 8'hFF, 24'h000000, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b1, 8'h55, 25'h0000000, 8'h00, 24'h000000, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h7F, 25'h0ABCDEF, 8'h7F, 24'hABCDEF, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h00, 25'h0800000, 8'h01, 24'h800000, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 8'h40, 25'h0000001, 8'h29, 24'h800000, 6'd23, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h20, 25'h1FFFFFE, 8'h21, 24'hFFFFFF, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h00, 25'h0000123, 8'h00, 24'h000123, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0);
    drain("directed");

    // Backpressure: result held 5 cycles while a second request waits at the input.
    OutReady = 1'b0;
    fork
      begin
        send(1'b1, 8'h10, 25'h0100000, 8'h0D, 24'h800000, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 8'h80, 25'h1800001, 8'h81, 24'hC00000, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      begin
        guard = 0;
        while (!OutValid && guard < 100) begin
          @(negedge Clk);
          guard++;
        end
        chk("bp_valid_timeout", 32'(guard < 100), 32'd1);
        repeat (5) @(negedge Clk);
        chk("bp_second_not_taken", 32'(sb.size()), 32'd0);
        OutReady = 1'b1;
      end
    join
    drain("backpressure");

    // Reset mid-normalisation drops the operation.
    send(1'b1, 8'h40, 25'h0000001, 8'h29, 24'h800000, 6'd23, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge Clk);
    chk("pre_reset_busy", 32'(InReady), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    check_all_zero("mid_reset");
    void'(sb.pop_front());
    n_sent--;
    Reset = 1'b0;

    send(1'b0, 8'h10, 25'h0100000, 8'h0D, 24'h800000, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("after_reset");
    repeat (3) @(negedge Clk);
    chk("handshake_count", 32'(n_done), 32'(n_sent));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
